// File: rtl/arm_pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// arm_pipe_ctrl_if
//   Bundles the signals between the 5-stage ARM pipeline and its pipeline-
//   control block (arm_pipe_ctrl).
//
//   master modport : pipeline side. Drives the ID-stage instruction fields,
//                    the EXE branch outcome and the external hold. Receives
//                    the control and forwarding outputs.
//   slave modport  : arm_pipe_ctrl side (the mirror image).
//
//   ID fields    : id_valid, id_src1, id_src2, id_two_src, id_wb_en,
//                  id_dest, id_mem_r_en
//   EXE/memory   : branch_taken, ext_stall
//   Control      : freeze, flush, bubble
//   Forwarding   : fwd_sel_a, fwd_sel_b (00 regfile, 01 MEM ALU, 10 WB)
//   Performance  : stall_cnt, flush_cnt
// ---------------------------------------------------------------------------
interface arm_pipe_ctrl_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic             id_wb_en;
  logic [REG_W-1:0] id_dest;
  logic             id_mem_r_en;
  logic             branch_taken;
  logic             ext_stall;

  logic             freeze;
  logic             flush;
  logic             bubble;
  logic [1:0]       fwd_sel_a;
  logic [1:0]       fwd_sel_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
           id_mem_r_en, branch_taken, ext_stall,
    input  freeze, flush, bubble, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
           id_mem_r_en, branch_taken, ext_stall,
    output freeze, flush, bubble, fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/arm_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// arm_pipe_ctrl
//   Pipeline-control block for the 5-stage ARM core. Keeps a registered
//   scoreboard of the instructions in flight after ID (slot0=EXE, slot1=MEM,
//   slot2=WB, further slots for deeper variants) and derives from it:
//     - the ID-stage freeze (holds PC and REG_PIPE_1),
//     - the branch flush (clears REG_PIPE_1 and REG_PIPE_2),
//     - the bubble insert (REG_PIPE_2 loads a NOP),
//     - the EXE operand-forwarding selects,
//     - saturating stall / flush performance counters.
//
//   Ports
//     clk : rising-edge clock
//     rst : synchronous active-low reset
//     bus : arm_pipe_ctrl_if.slave (ID fields, branch_taken, ext_stall in;
//           freeze, flush, bubble, fwd_sel_a/b, stall_cnt, flush_cnt out)
//
//   Parameters
//     STAGES : tracked post-ID slots, 3..8
//     REG_W  : register-address width
//     FWD_EN : 1 = stall only where forwarding cannot help; 0 = stall on RAW
//     CNT_W  : performance-counter width
// ---------------------------------------------------------------------------
module arm_pipe_ctrl #(
  parameter int STAGES = 3,
  parameter int REG_W  = 4,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  arm_pipe_ctrl_if.slave bus
);

  typedef logic [REG_W-1:0] reg_t;

  // One in-flight instruction. src fields only matter in slot0 (EXE), where
  // they steer the forwarding muxes.
  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r;
    logic two_src;
    reg_t dest;
    reg_t src1;
    reg_t src2;
  } slot_t;

  slot_t            slot_q [STAGES];
  slot_t            id_slot;
  logic             hazard;
  logic             flush_w;
  logic             bubble_w;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Slot s will write register r. r0 is an ordinary register here.
  function automatic logic match(slot_t s, reg_t r);
    return s.valid & s.wb_en & (s.dest == r);
  endfunction

  // The ID instruction reads the result of slot s.
  function automatic logic id_reads(slot_t s, reg_t src1, reg_t src2, logic two_src);
    return match(s, src1) | (two_src & match(s, src2));
  endfunction

  // Youngest producer wins: MEM ALU result first (a load in MEM has no data
  // yet), then the WB value, else the register file.
  function automatic logic [1:0] fwd_pick(slot_t mem_s, slot_t wb_s, reg_t r);
    if (match(mem_s, r) && !mem_s.mem_r) return 2'b01;
    if (match(wb_s, r))                  return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    id_slot = '{valid:   bus.id_valid,
                wb_en:   bus.id_wb_en,
                mem_r:   bus.id_mem_r_en,
                two_src: bus.id_two_src,
                dest:    bus.id_dest,
                src1:    bus.id_src1,
                src2:    bus.id_src2};
  end

  // RAW hazard against the ID instruction. The WB slot never stalls: the
  // register file is write-first. With forwarding, only a load in EXE and
  // slots beyond WB (deeper variants, no forwarding path) stall.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    hazard = 1'b0;
    if (bus.id_valid) begin
      if (FWD_EN) begin
        hazard = slot_q[0].mem_r &
                 id_reads(slot_q[0], bus.id_src1, bus.id_src2, bus.id_two_src);
        for (int k = 3; k <= STAGES - 2; k++) begin
          hazard |= id_reads(slot_q[k], bus.id_src1, bus.id_src2, bus.id_two_src);
        end
      end else begin
        for (int k = 0; k <= STAGES - 2; k++) begin
          hazard |= id_reads(slot_q[k], bus.id_src1, bus.id_src2, bus.id_two_src);
        end
      end
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN && slot_q[0].valid) begin
      fwd_a = fwd_pick(slot_q[1], slot_q[2], slot_q[0].src1);
      if (slot_q[0].two_src) begin
        fwd_b = fwd_pick(slot_q[1], slot_q[2], slot_q[0].src2);
      end
    end
  end

  // A taken branch kills the dependent instruction anyway, so it overrides
  // the hazard: no freeze, and the stall is not counted.
  assign flush_w  = bus.branch_taken & ~bus.ext_stall;
  assign bubble_w = ~bus.ext_stall & (hazard | flush_w);

  assign bus.flush     = flush_w;
  assign bus.freeze    = bus.ext_stall | (hazard & ~flush_w);
  assign bus.bubble    = bubble_w;
  assign bus.fwd_sel_a = fwd_a;
  assign bus.fwd_sel_b = fwd_b;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the scoreboard is a handful of flops, not a RAM, so every
      // slot is cleared explicitly; a stale valid bit would fake a hazard.
      for (int k = 0; k < STAGES; k++) begin
        slot_q[k] <= '0;
      end
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!bus.ext_stall) begin
      // NOTE: non-blocking assignments make every slot sample the old value
      // of its neighbour, so the shift order inside the loop is irrelevant.
      for (int k = STAGES - 1; k > 0; k--) begin
        slot_q[k] <= slot_q[k-1];
      end
      slot_q[0] <= bubble_w ? '0 : id_slot;

      if (hazard && !flush_w && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_w && flush_cnt_q != '1) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/arm_pipe_ctrl.md
Name: arm_pipe_ctrl

Overview:
- Parametrised pipeline-control block for the 5-stage ARM core.
- Replaces the tied-off hazard, freeze and flush wiring with one registered scoreboard of in-flight instructions.
- Generates the ID-stage freeze, the branch flush, the bubble insert and the EXE operand-forwarding selects.
- Adds saturating stall and flush performance counters. Sits beside ID_STAGE/EXE_STAGE and drives REG_PIPE_1, REG_PIPE_2 and the IF freeze.

Parameters:
STAGES, 3, number of tracked post-ID slots (slot0=EXE, slot1=MEM, slot2=WB, extra slots for deeper variants); legal range 3..8
REG_W, 4, register-address width
FWD_EN, 1, 1 = forwarding mode (stall only on load-use or un-forwardable slots); 0 = stall on any RAW
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_W  Rn of ID instruction
id_src2  in  REG_W  second source (Rm or Rd for store)
id_two_src  in  1  id_src2 is used
id_wb_en  in  1  ID instruction writes a register
id_dest  in  REG_W  ID destination
id_mem_r_en  in  1  ID instruction is a load
branch_taken  in  1  branch resolved taken in EXE this cycle
ext_stall  in  1  external hold (memory wait); freezes everything
freeze  out  1  hold PC and REG_PIPE_1
flush  out  1  clear REG_PIPE_1 and REG_PIPE_2
bubble  out  1  REG_PIPE_2 loads a NOP (control bits zero)
fwd_sel_a  out  2  EXE operand-A source: 00 regfile, 01 MEM ALU result, 10 WB value
fwd_sel_b  out  2  same for operand B
stall_cnt  out  CNT_W  cycles with hazard stall
flush_cnt  out  CNT_W  taken branches

Behaviour:
- Slot record, one per slot: valid, wb_en, dest, mem_r, src1, src2, two_src. The src fields are used in slot0 only.
- Match(k, s) = slot[k].valid & slot[k].wb_en & slot[k].dest==s. For src2, the match also requires two_src.
- hazard is combinational and valid only when id_valid:
  - FWD_EN=0: Match(k, id_src1 | id_src2) for any k in 0..STAGES-2. The WB slot is excluded because the register file is write-first.
  - FWD_EN=1: (slot0.mem_r & Match(0, src)), or Match(k, src) for any k in 3..STAGES-2.
- Output equations:
  - flush = branch_taken & ~ext_stall.
  - freeze = ext_stall | (hazard & ~flush).
  - bubble = ~ext_stall & (hazard | flush).
- Slot update at the rising edge, when ~ext_stall:
  - slot[k+1] <= slot[k] for k = 0..STAGES-2; the oldest slot retires.
  - If bubble, slot0 <= all-zero (valid=0).
  - Otherwise slot0 <= ID fields, with valid=id_valid.
- When ext_stall: all slots hold; no counter increments.
- Forwarding selects (combinational, from slot0 sources):
  - FWD_EN=1: fwd_sel = 01 if Match(1, src) & ~slot1.mem_r; else 10 if Match(2, src); else 00. Slot1 has priority (youngest).
  - FWD_EN=0: fwd_sel is constant 00.
  - When slot0.valid=0: fwd_sel is 00.
- Simultaneous branch_taken and hazard: flush wins. freeze=0 and bubble=1; the stall counter does not increment.
- Counters:
  - stall_cnt increments on cycles with hazard & ~flush & ~ext_stall.
  - flush_cnt increments on cycles with flush.
  - Both saturate at all-ones; no wrap.
- Reset (rst=0 at an edge, including mid-stall or mid-flush): all slots invalid, counters 0.
  - Combinational outputs then settle to freeze=ext_stall, flush=branch_taken&~ext_stall, bubble=flush, fwd_sel=00.
- Register 0 is an ordinary register: no r0-hardwired exception.
- Latency: hazard/flush response is same-cycle; scoreboard advances one slot per unstalled cycle.

Test Plan:
1. Reset then no traffic. Required: freeze=0, flush=0, bubble=0, fwd_sel_a=fwd_sel_b=00, counters 0.
2. FWD_EN=1, back-to-back ALU ops: ADD r2 (dest 2) followed by SUB with src1=2. Required: no stall; next cycle fwd_sel_a=01. One cycle later, a third instruction with src2=2, two_src=1, gives fwd_sel_b=10.
3. FWD_EN=1 load-use: LDR r3 then ADD with src1=3. Required: freeze=1 and bubble=1 for exactly 1 cycle, stall_cnt=1, then fwd_sel_a=10.
4. FWD_EN=0 dependent pair: dest 5 then src1 5. Required: freeze held 2 cycles (STAGES=3), stall_cnt=2, no forwarding.
5. branch_taken asserted in the same cycle as a load-use hazard. Required: flush=1, bubble=1, freeze=0, flush_cnt=1, stall_cnt unchanged.
6. ext_stall=1 for 4 cycles with a pending RAW. Required: slots frozen, counters frozen, freeze=1. Separately, preload stall_cnt to 0xFFFF and apply another stall: stall_cnt stays 0xFFFF. Separately, rst=0 mid-stall: all state clears next edge.
